// File: rtl/ram_wb_b3_burst.sv
// Wishbone B3 on-chip RAM slave: classic, constant and incrementing bursts (linear / wrap4/8/16).
// Latency: first ack or err one cycle after stb is sampled in IDLE; burst beats then ack every cycle stb is high.
// Backpressure: master waits by dropping stb inside a burst (address held, no ack); optional write
// protection via RAM_WB_B3_BURST_WPROT_EN adds wb_wp_i.
module ram_wb_b3_burst #(
  parameter int          dw             = 32,
  parameter int          aw             = 32,
  parameter logic [31:0] mem_size_bytes = 32'h0000_8000,
  parameter int          mem_adr_width  = 15,
  parameter string       memory_file    = ""
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic [1:0]      wb_bte_i,
  input  logic [2:0]      wb_cti_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o,
  output logic [dw-1:0]   wb_dat_o
`ifdef RAM_WB_B3_BURST_WPROT_EN
  ,
  input  logic            wb_wp_i
`endif
);

  localparam int sw    = dw / 8;
  localparam int lsb   = $clog2(sw);
  localparam int ww    = mem_adr_width - lsb;
  localparam int depth = int'(mem_size_bytes) / sw;
  localparam logic [ww-1:0] last_w = ww'(depth - 1);

  localparam logic [2:0] CTI_CONST = 3'b001;
  localparam logic [2:0] CTI_INCR  = 3'b010;
  localparam logic [2:0] CTI_END   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLASSIC,
    S_BURST,
    S_ERR
  } state_t;

  state_t          state, state_n;
  logic [ww-1:0]   bur_w;      // predicted word index of the current beat
  logic [ww-1:0]   nxt_w;      // word index of the beat after this one
  logic [ww-1:0]   adr_w;      // word index the master is driving now
  logic [ww-1:0]   rd_w;       // word to present on wb_dat_o next cycle
  logic            adr_oor;
  logic            wp;
  logic            ack, err, wr_en;

  logic [dw-1:0]   mem [0:depth-1];

`ifdef RAM_WB_B3_BURST_WPROT_EN
  assign wp = wb_wp_i;
`else
  assign wp = 1'b0;
`endif

  assign adr_w   = wb_adr_i[mem_adr_width-1:lsb];
  assign adr_oor = ({32'd0, wb_adr_i} >= {{aw{1'b0}}, mem_size_bytes});

  // Next burst word: linear wraps over the whole memory, wrap modes only cycle the low bits.
  always_comb begin
    nxt_w = bur_w;
    if (wb_cti_i == CTI_INCR) begin
      case (wb_bte_i)
        2'b00:   nxt_w = (bur_w == last_w) ? '0 : bur_w + 1'b1;
        2'b01:   nxt_w = {bur_w[ww-1:2], bur_w[1:0] + 2'd1};
        2'b10:   nxt_w = {bur_w[ww-1:3], bur_w[2:0] + 3'd1};
        default: nxt_w = {bur_w[ww-1:4], bur_w[3:0] + 4'd1};
      endcase
    end
  end

  // Next-state and handshake outputs; err always wins over ack and dropping cyc aborts everything.
  always_comb begin
    state_n = state;
    ack     = 1'b0;
    err     = 1'b0;
    wr_en   = 1'b0;
    if (!wb_cyc_i) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (wb_stb_i) begin
            if (adr_oor)
              state_n = S_ERR;
            else if (wb_cti_i == CTI_CONST || wb_cti_i == CTI_INCR)
              state_n = S_BURST;
            else
              state_n = S_CLASSIC;
          end
        end
        S_CLASSIC: begin
          state_n = S_IDLE;
          if (wb_stb_i) begin
            if (wb_we_i && wp) begin
              err = 1'b1;
            end else begin
              ack   = 1'b1;
              wr_en = wb_we_i;
            end
          end
        end
        S_BURST: begin
          if (wb_stb_i) begin
            if (adr_oor || (adr_w != bur_w) || (wb_we_i && wp)) begin
              err     = 1'b1;
              state_n = S_IDLE;
            end else begin
              ack   = 1'b1;
              wr_en = wb_we_i;
              if (wb_cti_i == CTI_END)
                state_n = S_IDLE;
            end
          end
        end
        S_ERR: begin
          err     = 1'b1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign wb_ack_o = ack;
  assign wb_err_o = err;
  assign wb_rty_o = 1'b0;

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // Burst address: captured when a cycle starts, advanced on every acked burst beat.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      bur_w <= '0;
    else if (state == S_IDLE && wb_cyc_i && wb_stb_i)
      bur_w <= adr_w;
    else if (state == S_BURST && ack)
      bur_w <= nxt_w;
  end

  // Read word for next cycle follows the address register so data lines up with ack.
  always_comb begin
    rd_w = bur_w;
    if (state == S_IDLE)
      rd_w = adr_w;
    else if (state == S_BURST && ack)
      rd_w = nxt_w;
  end

  // Registered read data.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      wb_dat_o <= '0;
    else
      wb_dat_o <= mem[rd_w];
  end

  // Byte-lane write on acked write beats; reset in flight blocks the write.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en && !wb_rst_i) begin
      for (int i = 0; i < sw; i++) begin
        if (wb_sel_i[i])
          mem[bur_w][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram_wb_b3_burst.sv
// Bench for ram_wb_b3_burst: directed scenarios plus random bursts against a word-array model.
// Latency: checks first-beat and per-beat ack timing.
// Backpressure: exercises master waits (stb low) inside bursts.
module tb_ram_wb_b3_burst;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we  = 1'b0;
  logic [1:0]  bte = '0;
  logic [2:0]  cti = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        ack, err, rty;
  logic [31:0] dat_o;

  logic [31:0] mdl [0:DEPTH-1];
  int n_vec = 0;
  int n_bad = 0;

  ram_wb_b3_burst #(
    .dw(32), .aw(32), .mem_size_bytes(32'h400), .mem_adr_width(10)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_bte_i(bte), .wb_cti_i(cti), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_dat_o(dat_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Address sequence from the bus rules: constant holds, linear steps mod depth, wrap-N cycles in an N-aligned block.
  function automatic int model_next(input int w, input logic [2:0] c, input logic [1:0] bt);
    int len;
    if (c != 3'b010) return w;
    if (bt == 2'b00) return (w + 1) % DEPTH;
    len = 2 << bt;
    return (w / len) * len + (w + 1) % len;
  endfunction

  task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) mdl[w][8*i +: 8] = d[8*i +: 8];
  endtask

  // Starts at posedge+1; returns at posedge+1 after the edge that consumed the response.
  task automatic drive_beat(input logic [31:0] a, input bit w_en, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] c, input logic [1:0] bt,
                            output int lat, output bit got_ack, output bit got_err,
                            output logic [31:0] rd);
    cyc = 1'b1; stb = 1'b1; adr = a; we = w_en; dat = d; sel = s; cti = c; bte = bt;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack && !err && lat < 8);
    got_ack = ack;
    got_err = err;
    rd      = dat_o;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; sel = '0;
    @(posedge clk); #1;
  endtask

  task automatic classic(input string tag, input int w, input bit w_en, input logic [31:0] d,
                         input logic [3:0] s);
    int lat; bit a, e; logic [31:0] rd;
    drive_beat(w * 4, w_en, d, s, 3'b000, 2'b00, lat, a, e, rd);
    idle();
    check({tag, "_ack"}, a, 1);
    check({tag, "_lat"}, lat, 2);
    if (w_en) model_write(w, d, s);
    else check({tag, "_rdata"}, rd, mdl[w]);
  endtask

  task automatic run_burst(input int w0, input int n, input bit w_en, input logic [1:0] bt,
                           input bit konst, input bit full, input int wait_at, input int wait_len);
    int w, lat; bit a, e; logic [31:0] d, rd; logic [3:0] s; logic [2:0] c;
    w = w0;
    for (int b = 0; b < n; b++) begin
      if (b == wait_at) begin
        stb = 1'b0;
        for (int k = 0; k < wait_len; k++) begin
          @(negedge clk);
          check("wait_ack", ack, 0);
          @(posedge clk); #1;
        end
      end
      d = $urandom;
      s = full ? 4'hF : 4'($urandom_range(0, 15));
      c = (b == n - 1) ? 3'b111 : (konst ? 3'b001 : 3'b010);
      drive_beat(w * 4, w_en, d, s, c, bt, lat, a, e, rd);
      check("burst_ack", a, 1);
      check("burst_lat", lat, (b == 0) ? 2 : 1);
      if (w_en) model_write(w, d, s);
      else check("burst_rdata", rd, mdl[w]);
      w = model_next(w, c, bt);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat; bit a, e; logic [31:0] rd, old;

    #3;
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_rty", rty, 0);
    check("rst_dat", dat_o, 0);
    #20 rst = 1'b0;
    @(posedge clk); #1;

    // Fill memory with linear full-lane bursts so the model is fully known.
    for (int i = 0; i < DEPTH / 16; i++)
      run_burst(i * 16, 16, 1'b1, 2'b00, 1'b0, 1'b1, -1, 0);

    // Classic partial-lane write over all-ones, then read back.
    classic("cl_w1", 4, 1'b1, 32'hFFFF_FFFF, 4'hF);
    classic("cl_w2", 4, 1'b1, 32'hA5A5_1234, 4'b0011);
    classic("cl_rd", 4, 1'b0, 32'h0, 4'h0);
    check("cl_value", mdl[4], 32'hFFFF_1234);

    // Held stb on a classic cycle acks every other cycle.
    cyc = 1'b1; stb = 1'b1; adr = 32'h0; we = 1'b0; cti = 3'b000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("held_stb_ack", ack, (k % 2 == 1) ? 1 : 0);
    end
    @(posedge clk); #1;
    idle();
    idle();

    // Wrap4 read from 0x18: words 6,7,4,5 on consecutive cycles.
    run_burst(6, 4, 1'b0, 2'b01, 1'b0, 1'b0, -1, 0);

    // Linear read from 0 with a two-cycle master wait before the third beat.
    run_burst(0, 4, 1'b0, 2'b00, 1'b0, 1'b0, 2, 2);

    // Address mismatch on beat 2 of a linear write burst starting at 0x1C.
    old = mdl[8];
    drive_beat(32'h1C, 1'b1, 32'h1111_2222, 4'hF, 3'b010, 2'b00, lat, a, e, rd);
    check("mm_beat1_ack", a, 1);
    model_write(7, 32'h1111_2222, 4'hF);
    drive_beat(32'h24, 1'b1, 32'h3333_4444, 4'hF, 3'b010, 2'b00, lat, a, e, rd);
    idle();
    check("mm_err", e, 1);
    check("mm_ack", a, 0);
    check("mm_lat", lat, 1);
    classic("mm_w8", 8, 1'b0, 32'h0, 4'h0);
    check("mm_w8_kept", mdl[8], old);
    classic("mm_w9", 9, 1'b0, 32'h0, 4'h0);
    classic("mm_w7", 7, 1'b0, 32'h0, 4'h0);

    // Out-of-range classic read: single err pulse, no ack.
    drive_beat(32'h400, 1'b0, 32'h0, 4'h0, 3'b000, 2'b00, lat, a, e, rd);
    check("oor_err", e, 1);
    check("oor_ack", a, 0);
    check("oor_lat", lat, 2);
    idle();
    @(negedge clk);
    check("oor_err_pulse", err, 0);
    @(posedge clk); #1;

    // Linear write burst running off the end of memory errors on the out-of-range beat.
    old = mdl[0];
    run_burst(254, 1, 1'b1, 2'b00, 1'b0, 1'b1, -1, 0);
    drive_beat(32'h3F8, 1'b1, 32'hCAFE_0001, 4'hF, 3'b010, 2'b00, lat, a, e, rd);
    check("cross_b0_ack", a, 1);
    model_write(254, 32'hCAFE_0001, 4'hF);
    drive_beat(32'h3FC, 1'b1, 32'hCAFE_0002, 4'hF, 3'b010, 2'b00, lat, a, e, rd);
    check("cross_b1_ack", a, 1);
    model_write(255, 32'hCAFE_0002, 4'hF);
    drive_beat(32'h400, 1'b1, 32'hCAFE_0003, 4'hF, 3'b010, 2'b00, lat, a, e, rd);
    idle();
    check("cross_err", e, 1);
    check("cross_ack", a, 0);
    classic("cross_w0", 0, 1'b0, 32'h0, 4'h0);
    check("cross_w0_kept", mdl[0], old);
    classic("cross_w255", 255, 1'b0, 32'h0, 4'h0);

    // Reset asserted during beat 3 of an 8-beat linear write burst at word 16.
    drive_beat(32'h40, 1'b1, 32'h0BAD_0010, 4'hF, 3'b010, 2'b00, lat, a, e, rd);
    check("rstb_b0_ack", a, 1);
    model_write(16, 32'h0BAD_0010, 4'hF);
    drive_beat(32'h44, 1'b1, 32'h0BAD_0011, 4'hF, 3'b010, 2'b00, lat, a, e, rd);
    check("rstb_b1_ack", a, 1);
    model_write(17, 32'h0BAD_0011, 4'hF);
    old = mdl[18];
    cyc = 1'b1; stb = 1'b1; adr = 32'h48; we = 1'b1; dat = ~old; sel = 4'hF; cti = 3'b010;
    #2 rst = 1'b1;
    #1;
    check("rstb_ack", ack, 0);
    check("rstb_err", err, 0);
    check("rstb_dat", dat_o, 0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    classic("rstb_w18", 18, 1'b0, 32'h0, 4'h0);
    check("rstb_w18_kept", mdl[18], old);
    classic("rstb_w0", 0, 1'b0, 32'h0, 4'h0);
    classic("rstb_w17", 17, 1'b0, 32'h0, 4'h0);

    // Random bursts of all kinds, with random master waits.
    for (int t = 0; t < 24; t++) begin
      int n, w0, wat;
      bit w_en, konst;
      logic [1:0] bt;
      n     = $urandom_range(2, 8);
      bt    = 2'($urandom_range(0, 3));
      konst = ($urandom_range(0, 3) == 0);
      w_en  = $urandom_range(0, 1);
      w0    = $urandom_range(0, DEPTH - 1 - n);
      wat   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
      run_burst(w0, n, w_en, bt, konst, 1'b0, wat, $urandom_range(1, 3));
    end

    // Random classic reads of the whole model.
    for (int t = 0; t < 16; t++)
      classic("rnd_cl_rd", $urandom_range(0, DEPTH - 1), 1'b0, 32'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
